iic_target: RTL
===============

Name: iic_target

Overview:
- Bit-level IIC target (responder) for the other end of the bus driven by the team's IIC initiator.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address and ACKs it.
- On write transfers, delivers received bytes to the core; on read transfers, shifts core-supplied bytes out.

Parameters:
- word_width, 8: data byte width in bits (IIC framing needs 8; other values only for simulation).
- TARGET_ADDR, 7'h42: 7-bit address this target answers.
- SYNC_STAGES, 2: synchronizer depth on SCL_IN/SDA_IN; minimum 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- SCL_IN  input  1  bus clock as seen on the pad.
- SDA_IN  input  1  bus data as seen on the pad.
- SDA_OUT  output  1  open-drain data drive; 0 = pull low, 1 = release.
- RX_DATA  output  word_width  last byte received in a write transfer.
- RX_VALID  output  1  one-cycle pulse; RX_DATA is new.
- TX_DATA  input  word_width  byte to return in a read transfer; sampled when TX_REQ pulses.
- TX_REQ  output  1  one-cycle pulse; TX_DATA is captured in that same cycle.
- BUSY  output  1  high from an addressed START until STOP or NACK.

Behaviour:
- Reset (async): SDA_OUT=1, RX_DATA=0, RX_VALID=0, TX_REQ=0, BUSY=0, state=IDLE, bit counter=0.
- Reset mid-transfer releases SDA immediately, without waiting for a clock edge.
- Inputs pass through SYNC_STAGES flops. Edges are found by comparing the synchronized value with its previous sample. All decisions below use the synchronized signals.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Data bits are sampled in the cycle a rising SCL edge is detected.
- SDA_OUT changes only in the cycle a falling SCL edge is detected, so it never changes while SCL is high.
- START/STOP priority: START (including repeated START) in any state -> ADDR, counter cleared, SDA_OUT=1. STOP in any state -> IDLE, SDA_OUT=1, BUSY=0. Both take priority over bit handling in the same cycle.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7 address bits, then R/W). After the 8th rising edge: if addr==TARGET_ADDR -> ADDR_ACK and BUSY=1, else -> WAIT_STOP.
  - ADDR_ACK: on the falling edge, SDA_OUT=0. On the next falling edge, SDA_OUT=1. Then R/W=0 -> RX_BYTE; R/W=1 -> TX_REQ pulse, load the shifter from TX_DATA, drive the MSB, -> TX_BYTE.
  - RX_BYTE: shift 8 bits. After the 8th rising edge: RX_DATA updated and RX_VALID pulses in that cycle; -> RX_ACK.
  - RX_ACK: drive the ACK low for one SCL period, exactly as in ADDR_ACK, then -> RX_BYTE.
  - TX_BYTE: drive the next bit on each falling edge. After the 8th bit's falling edge, SDA_OUT=1 -> TX_ACK.
  - TX_ACK: sample the initiator's ACK on the rising edge. ACK (0) -> TX_REQ pulse, reload, next falling edge drives the MSB, -> TX_BYTE. NACK (1) -> WAIT_STOP with BUSY=0.
  - WAIT_STOP: SDA released; ignore bits until START or STOP.
- Counter width is $clog2(word_width)+1. It wraps to 0 on every byte boundary.
- Simultaneous events:
  - RX_VALID and TX_REQ never pulse in the same cycle.
  - A START arriving during a TX_DATA driven low releases SDA in that cycle.
- Latency: RX_VALID asserts SYNC_STAGES+1 clk cycles after the 8th SCL rise at the pad.
- The ACK low is held at least until the falling SCL edge after the ACK bit.

Decomposition:
- Shared package iic_pkg:
  - state enum iic_target_state_t {IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP};
  - constants IIC_ACK=1'b0, IIC_NACK=1'b1, IIC_RW_WRITE=1'b0.
- Sub-module iic_line_sync: parameterized synchronizer plus rise/fall pulse outputs, with async reset to 1 (the idle bus level). Instantiate it once for SCL and once for SDA.

Test Plan:
- Write address 0x42 (byte 0x84), data 0xA5 then 0x3C, STOP:
  - ACK driven low at three ACK slots;
  - RX_VALID pulses twice with RX_DATA=0xA5, then 0x3C;
  - BUSY drops at STOP.
- Address 0x43, write:
  - SDA_OUT stays 1 throughout, no RX_VALID, BUSY stays 0;
  - a following STOP then START to 0x42 is ACKed.
- Read 0x42 (byte 0x85), TX_DATA=0xC3 then 0x5A, initiator ACKs byte 1 and NACKs byte 2:
  - bits 11000011 then 01011010 appear on SDA;
  - TX_REQ pulses exactly twice;
  - SDA released after the NACK.
- Repeated START after 4 bits of a write data byte, then read from 0x42:
  - no RX_VALID for the partial byte;
  - address re-decoded;
  - TX_REQ pulses.
- Assert rst while SDA_OUT=0 during an ACK: SDA_OUT=1 in the same cycle and all outputs return to reset values.
- SDA toggles while SCL low between bits (legal data change): no false START/STOP; byte 0x81 received intact.

Source files
------------

// File: rtl/iic_pkg.sv
// iic_pkg: shared FSM state type and bus-level constants for the IIC target.
package iic_pkg;
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } iic_target_state_t;
    localparam logic IIC_ACK      = 1'b0;
    localparam logic IIC_NACK     = 1'b1;
    localparam logic IIC_RW_WRITE = 1'b0;
endpackage

// File: rtl/iic_target_if.sv
// iic_target_if: pad-side bus lines and core-side byte handshake of the IIC target.
interface iic_target_if #(parameter int word_width = 8);
    logic                  SCL_IN;
    logic                  SDA_IN;
    logic                  SDA_OUT;
    logic [word_width-1:0] RX_DATA;
    logic                  RX_VALID;
    logic [word_width-1:0] TX_DATA;
    logic                  TX_REQ;
    logic                  BUSY;
    modport master (output SCL_IN, SDA_IN, TX_DATA, input SDA_OUT, RX_DATA, RX_VALID, TX_REQ, BUSY);
    modport slave  (input SCL_IN, SDA_IN, TX_DATA, output SDA_OUT, RX_DATA, RX_VALID, TX_REQ, BUSY);
endinterface

// File: rtl/iic_line_sync.sv
// iic_line_sync: multi-flop synchronizer for one bus line with rise/fall pulses.
// Resets to 1 so an idle (pulled-up) bus produces no spurious edge after reset.
module iic_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], line_i};
            prev_q <= sync_q[STAGES-1];
        end
    end
    assign line_o = sync_q[STAGES-1];
    assign rise_o = line_o & ~prev_q;
    assign fall_o = ~line_o & prev_q;
endmodule

// File: rtl/iic_target.sv
// iic_target: oversampled bit-level IIC responder at a fixed 7-bit address.
// Bytes written by the initiator go to RX_DATA; read bytes come from TX_DATA on TX_REQ.
module iic_target
    import iic_pkg::*;
#(
    parameter int         word_width  = 8,
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input logic         clk,
    input logic         rst,
    iic_target_if.slave bus
);
    localparam int W  = word_width;
    localparam int CW = $clog2(word_width) + 1;
    localparam logic [CW-1:0] LAST = CW'(word_width - 1);

    logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
    iic_target_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  shift_q, shift_d, rx_data_q, rx_data_d, shift_in;
    logic sda_q, sda_d, busy_q, busy_d, rx_valid_q, rx_valid_d;
    logic rw_q, rw_d, ack_q, ack_d, tx_req, start, stop;

    iic_line_sync #(.STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst(rst), .line_i(bus.SCL_IN), .line_o(scl), .rise_o(scl_rise), .fall_o(scl_fall)
    );
    iic_line_sync #(.STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst(rst), .line_i(bus.SDA_IN), .line_o(sda), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    assign start    = scl & sda_fall;
    assign stop     = scl & sda_rise;
    assign shift_in = {shift_q[W-2:0], sda};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            sda_q      <= sda_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
        end
    end

    // ack_q marks the second half of an ACK slot (ADDR_ACK/RX_ACK) or a received ACK (TX_ACK)
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        sda_d      = sda_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rw_d       = rw_q;
        ack_d      = ack_q;
        tx_req     = 1'b0;
        if (start) begin
            state_d = ADDR;
            cnt_d   = '0;
            sda_d   = 1'b1;
            ack_d   = 1'b0;
        end else if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
            ack_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        rw_d    = sda;
                        state_d = (shift_in[W-1 -: 7] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
                        busy_d  = (shift_in[W-1 -: 7] == TARGET_ADDR);
                    end
                end
                ADDR_ACK, RX_ACK: if (scl_fall) begin
                    ack_d = ~ack_q;
                    sda_d = ack_q ? 1'b1 : IIC_ACK;
                    if (ack_q) begin
                        if (state_q == ADDR_ACK && rw_q != IIC_RW_WRITE) begin
                            tx_req  = 1'b1;
                            shift_d = bus.TX_DATA;
                            sda_d   = bus.TX_DATA[W-1];
                            state_d = TX_BYTE;
                        end else begin
                            state_d = RX_BYTE;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d      = '0;
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        state_d    = RX_ACK;
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    shift_d = shift_q << 1;
                    sda_d   = shift_q[W-2];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sda_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = TX_ACK;
                    end
                end
                TX_ACK: begin
                    if (scl_rise && !ack_q) begin
                        state_d = (sda == IIC_NACK) ? WAIT_STOP : TX_ACK;
                        busy_d  = (sda != IIC_NACK);
                        ack_d   = (sda != IIC_NACK);
                    end else if (scl_fall && ack_q) begin
                        ack_d   = 1'b0;
                        tx_req  = 1'b1;
                        shift_d = bus.TX_DATA;
                        sda_d   = bus.TX_DATA[W-1];
                        state_d = TX_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.SDA_OUT  = sda_q;
    assign bus.RX_DATA  = rx_data_q;
    assign bus.RX_VALID = rx_valid_q;
    assign bus.TX_REQ   = tx_req;
    assign bus.BUSY     = busy_q;
endmodule
